// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode.
// Holds {instr, pc} pairs. Raises an early stall one slot before full,
// which covers the fetch register's one-cycle latency. An EXE redirect
// (flush_v_q_i) discards every entry.
module fetch_queue #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned XLEN  = 32,
    localparam int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_v_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            stall_o,
    output logic            full_o,
    input  logic            flush_v_q_i,
    output logic            instr_v_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            dec_ready_i,
    output logic [CNTW-1:0] count_o,
    output logic            overflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]     r_instr_mem [DEPTH];
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CNTW-1:0] r_count;
    logic            r_overflow;

    logic            w_full;
    logic            w_instr_v;
    logic            w_push;
    logic            w_pop;

    // Occupancy flags, handshake qualifiers and head-of-queue outputs
    always_comb begin
        w_full     = (r_count == CNTW'(DEPTH));
        w_instr_v  = (r_count != '0) & ~flush_v_q_i;
        w_push     = push_v_i & ~w_full & ~flush_v_q_i;
        w_pop      = w_instr_v & dec_ready_i;
        stall_o    = (r_count >= CNTW'(DEPTH - 1));
        full_o     = w_full;
        instr_v_o  = w_instr_v;
        instr_o    = r_instr_mem[r_rd_ptr];
        pc_o       = r_pc_mem[r_rd_ptr];
        count_o    = r_count;
        overflow_o = r_overflow;
    end

    // Entry storage: written at the tail on an accepted push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_instr_mem[i] <= '0;
                r_pc_mem[i]    <= '0;
            end
        end else if (w_push) begin
            r_instr_mem[r_wr_ptr] <= instr_i;
            r_pc_mem[r_wr_ptr]    <= pc_i;
        end
    end

    // Pointers and occupancy; a flush overrides any push or pop in that cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_v_q_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a push presented while full is lost; only reset clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (push_v_i & w_full) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios followed by random traffic.
// A driver keeps an abstract occupancy model and queues expected entries;
// a separate monitor checks status flags every cycle and pops the queue
// on every decode handshake.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNTW  = $clog2(DEPTH + 1);

    logic            clk;
    logic            reset;
    logic            push_v_i;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            stall_o;
    logic            full_o;
    logic            flush_v_q_i;
    logic            instr_v_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;
    logic            dec_ready_i;
    logic [CNTW-1:0] count_o;
    logic            overflow_o;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_v_i   (push_v_i),
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .stall_o    (stall_o),
        .full_o     (full_o),
        .flush_v_q_i(flush_v_q_i),
        .instr_v_o  (instr_v_o),
        .instr_o    (instr_o),
        .pc_o       (pc_o),
        .dec_ready_i(dec_ready_i),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } ent_t;

    ent_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: occupancy now, and occupancy after the coming edge
    int          m_count = 0;
    int          m_next  = 0;
    bit          m_ovf      = 0;
    bit          m_ovf_next = 0;
    bit          started    = 0;
    logic [XLEN-1:0] next_pc = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model advances by the queue's rules
    task automatic cycle(input bit p, input bit r, input bit f);
        bit acc;
        bit pop;
        @(posedge clk);
        #1;
        m_count = m_next;
        m_ovf   = m_ovf_next;
        if (f && p && m_count == DEPTH) p = 1'b0;
        push_v_i    = p;
        dec_ready_i = r;
        flush_v_q_i = f;
        instr_i     = $urandom;
        pc_i        = next_pc;
        if (p && m_count == DEPTH) m_ovf_next = 1'b1;
        if (f) begin
            m_next = 0;
            sb.delete();
        end else begin
            acc = p && (m_count < DEPTH);
            pop = r && (m_count != 0);
            if (acc) begin
                sb.push_back('{instr: instr_i, pc: pc_i});
                next_pc = next_pc + 4;
            end
            m_next = m_count + int'(acc) - int'(pop);
        end
    endtask

    // Monitor: status flags every cycle, head data on each handshake
    always @(negedge clk) begin
        ent_t e;
        if (started && !reset) begin
            check("count",    64'(count_o),    64'(m_count));
            check("full",     64'(full_o),     64'(m_count == DEPTH));
            check("stall",    64'(stall_o),    64'(m_count >= DEPTH - 1));
            check("overflow", 64'(overflow_o), 64'(m_ovf));
            check("instr_v",  64'(instr_v_o),  64'(m_count != 0 && !flush_v_q_i));
            if (instr_v_o && dec_ready_i) begin
                if (sb.size() == 0) begin
                    check("pop_nonempty", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("head_instr", 64'(instr_o), 64'(e.instr));
                    check("head_pc",    64'(pc_o),    64'(e.pc));
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        push_v_i    = 1'b0;
        dec_ready_i = 1'b0;
        flush_v_q_i = 1'b0;
        instr_i     = '0;
        pc_i        = '0;
        #2;
        check("rst_instr_v",  64'(instr_v_o),  64'd0);
        check("rst_count",    64'(count_o),    64'd0);
        check("rst_stall",    64'(stall_o),    64'd0);
        check("rst_full",     64'(full_o),     64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);
        check("rst_instr",    64'(instr_o),    64'd0);
        check("rst_pc",       64'(pc_o),       64'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        started = 1'b1;

        // In-order delivery of A (0x100) and B (0x104)
        next_pc = 'h100;
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        repeat (3) cycle(0, 1, 0);

        // Fill to DEPTH with decode stalled, then push while full
        repeat (4) cycle(1, 0, 0);
        cycle(1, 0, 0);
        repeat (2) cycle(0, 1, 0);

        // Steady push+pop at count=2 across pointer wrap
        repeat (10) cycle(1, 1, 0);

        // Flush with push and ready at count=3
        cycle(1, 0, 0);
        cycle(1, 1, 1);
        repeat (2) cycle(0, 0, 0);

        // Random traffic
        repeat (2000) begin
            cycle($urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 4);
        end

        // Asynchronous reset mid-operation at count=2
        cycle(0, 0, 1);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        check("pre_rst_count", 64'(count_o), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_instr_v",  64'(instr_v_o),  64'd0);
        check("async_count",    64'(count_o),    64'd0);
        check("async_stall",    64'(stall_o),    64'd0);
        check("async_overflow", 64'(overflow_o), 64'd0);
        check("async_full",     64'(full_o),     64'd0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        m_count    = 0;
        m_next     = 0;
        m_ovf      = 0;
        m_ovf_next = 0;
        sb.delete();
        repeat (4) cycle(1, 1, 0);
        repeat (4) cycle(0, 1, 0);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
